// File: rtl/uart_tx_wrapper_pkg.sv
// Shared types and helpers for the word-oriented UART transmitter.
//   uart_tx_state_t     : byte-level serializer states
//   UART_BYTES_PER_WORD : bytes per transmitted word (LSB first)
//   calc_clks_per_bit   : clk cycles per serial bit (integer truncation)
package uart_tx_wrapper_pkg;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } uart_tx_state_t;

    localparam int unsigned UART_BYTES_PER_WORD = 4;

    function automatic int unsigned calc_clks_per_bit(input int unsigned clk_freq,
                                                      input int unsigned baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Byte serializer: baud counter plus start/data/(parity)/stop FSM.
// Optional macro UART_TX_PARITY_EN inserts an even parity bit (8E1).
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   start        : begin a byte; honoured in IDLE or in the last STOP cycle
//   byte_in      : byte sampled on the accepting edge
//   tx           : serial line (flop output, idle high)
//   done         : high during the final cycle of the stop bit
//   idle         : serializer is in IDLE
module uart_tx_byte
    import uart_tx_wrapper_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 100_000_000,
    parameter int unsigned BAUD_RATE = 115_200
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] byte_in,
    output logic       tx,
    output logic       done,
    output logic       idle
);

    localparam int unsigned CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    uart_tx_state_t   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       byte_q, byte_d;
    logic             tx_q, tx_d;
    logic             done_q, done_d;
    logic             idle_q, idle_d;
    logic             bit_end;

    assign bit_end = (cnt_q == CNT_LAST);

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= TX_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            byte_q    <= '0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
            idle_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            byte_q    <= byte_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
            idle_q    <= idle_d;
        end
    end

    // Next state; tx is computed for the bit that begins on the next edge
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        byte_d    = byte_q;
        tx_d      = tx_q;
        if (state_q != TX_IDLE && !bit_end) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        case (state_q)
            TX_IDLE: begin
                tx_d = 1'b1;
                if (start) begin
                    state_d = TX_START;
                    cnt_d   = '0;
                    byte_d  = byte_in;
                    tx_d    = 1'b0;
                end
            end
            TX_START: begin
                if (bit_end) begin
                    state_d   = TX_DATA;
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    tx_d      = byte_q[0];
                end
            end
            TX_DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = TX_PARITY;
                        tx_d    = ^byte_q;
`else
                        state_d = TX_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = byte_q[bit_idx_d];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            TX_PARITY: begin
                if (bit_end) begin
                    state_d = TX_STOP;
                    cnt_d   = '0;
                    tx_d    = 1'b1;
                end
            end
`endif
            TX_STOP: begin
                // A start in the last stop cycle chains the next byte with no idle bit
                if (bit_end) begin
                    cnt_d = '0;
                    if (start) begin
                        state_d = TX_START;
                        byte_d  = byte_in;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = TX_IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = TX_IDLE;
                cnt_d   = '0;
                tx_d    = 1'b1;
            end
        endcase
        done_d = (state_d == TX_STOP) && (cnt_d == CNT_LAST);
        idle_d = (state_d == TX_IDLE);
    end

    assign tx   = tx_q;
    assign done = done_q;
    assign idle = idle_q;

endmodule

// File: rtl/uart_tx_wrapper.sv
// Word-oriented UART transmitter: word FIFO, byte sequencer (LSB byte first)
// and a transmitted-word counter. Optional macro UART_TX_PARITY_EN selects
// 8E1 framing in the byte serializer; default is 8N1.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   data_in      : 32-bit word to transmit
//   data_valid   : data_in valid; captured when data_ready is also high
//   data_ready   : FIFO not full (registered)
//   io_tx        : serial output, idle high
//   busy         : FIFO non-empty or a word in flight
//   words_sent   : fully transmitted words, wraps modulo 2^16
module uart_tx_wrapper
    import uart_tx_wrapper_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD_RATE  = 115_200,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] data_in,
    input  logic        data_valid,
    output logic        data_ready,
    output logic        io_tx,
    output logic        busy,
    output logic [15:0] words_sent
);

    localparam int unsigned IDX_W = $clog2(FIFO_DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    logic [31:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [31:0]      shift_q, shift_d;
    logic [1:0]       byte_idx_q, byte_idx_d;
    logic             word_active_q, word_active_d;
    logic             start_q, start_d;
    logic [15:0]      words_sent_q, words_sent_d;
    logic             data_ready_q, busy_q;
    logic             full_d, empty_d, busy_d;

    logic        empty, push, pop, idle_pop, last_byte, next_byte_c;
    logic        byte_start, byte_done, byte_idle;
    logic [7:0]  byte_in;
    logic [31:0] head;

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign head      = mem[rd_ptr_q[IDX_W-1:0]];
    assign push      = data_valid && data_ready_q;
    assign last_byte = (byte_idx_q == 2'(UART_BYTES_PER_WORD - 1));

    // Fresh word from idle; or chained pop at the end of the last byte's stop bit
    assign idle_pop    = !word_active_q && byte_idle && !empty;
    assign pop         = idle_pop || (byte_done && last_byte && !empty);
    assign next_byte_c = byte_done && (!last_byte || !empty);
    assign byte_start  = start_q || next_byte_c;
    assign byte_in     = next_byte_c ? (last_byte ? head[7:0] : shift_q[15:8]) : shift_q[7:0];

    // FIFO storage
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q[IDX_W-1:0]] <= data_in;
        end
    end

    // Sequencer and status registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            shift_q       <= '0;
            byte_idx_q    <= '0;
            word_active_q <= 1'b0;
            start_q       <= 1'b0;
            words_sent_q  <= '0;
            data_ready_q  <= 1'b1;
            busy_q        <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            shift_q       <= shift_d;
            byte_idx_q    <= byte_idx_d;
            word_active_q <= word_active_d;
            start_q       <= start_d;
            words_sent_q  <= words_sent_d;
            data_ready_q  <= !full_d;
            busy_q        <= busy_d;
        end
    end

    // Next-state for pointers, current word and counters
    always_comb begin
        wr_ptr_d      = wr_ptr_q + PTR_W'(push);
        rd_ptr_d      = rd_ptr_q + PTR_W'(pop);
        shift_d       = shift_q;
        byte_idx_d    = byte_idx_q;
        word_active_d = word_active_q;
        words_sent_d  = words_sent_q;
        start_d       = idle_pop;
        if (idle_pop) begin
            shift_d       = head;
            byte_idx_d    = '0;
            word_active_d = 1'b1;
        end else if (byte_done) begin
            if (last_byte) begin
                words_sent_d = words_sent_q + 16'd1;
                if (!empty) begin
                    shift_d    = head;
                    byte_idx_d = '0;
                end else begin
                    word_active_d = 1'b0;
                end
            end else begin
                shift_d    = shift_q >> 8;
                byte_idx_d = byte_idx_q + 2'd1;
            end
        end
        full_d  = (wr_ptr_d[PTR_W-1] != rd_ptr_d[PTR_W-1]) &&
                  (wr_ptr_d[IDX_W-1:0] == rd_ptr_d[IDX_W-1:0]);
        empty_d = (wr_ptr_d == rd_ptr_d);
        busy_d  = !empty_d || word_active_d;
    end

    uart_tx_byte #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE)
    ) u_byte (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (byte_start),
        .byte_in (byte_in),
        .tx      (io_tx),
        .done    (byte_done),
        .idle    (byte_idle)
    );

    assign data_ready = data_ready_q;
    assign busy       = busy_q;
    assign words_sent = words_sent_q;

endmodule

// File: tb/tb_uart_tx_wrapper.sv
// Directed bench for uart_tx_wrapper at 4 clk per bit, FIFO depth 4.
module tb_uart_tx_wrapper;

    localparam int unsigned CLK_FREQ   = 400;
    localparam int unsigned BAUD_RATE  = 100;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned N          = 4;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned FB = 11;
`else
    localparam int unsigned FB = 10;
`endif
    localparam int unsigned WORD_CYC = 4 * FB * N;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] data_in;
    logic        data_valid;
    logic        data_ready;
    logic        io_tx;
    logic        busy;
    logic [15:0] words_sent;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_tx_wrapper #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD_RATE  (BAUD_RATE),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .io_tx      (io_tx),
        .busy       (busy),
        .words_sent (words_sent)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] w);
        data_in    = w;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
    endtask

    // Frame bit k of a byte: start, 8 data bits LSB first, [even parity], stop
    function automatic logic frame_bit(input logic [7:0] d, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
`ifdef UART_TX_PARITY_EN
        if (k == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    // Called at the first cycle of a word's first start bit; every cycle of every bit is sampled
    task automatic check_word(input logic [31:0] w, input string tag);
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < int'(FB); k++) begin
                logic [7:0]  byt;
                logic [31:0] obs;
                logic [31:0] exp;
                byt = w[8*b +: 8];
                obs = '0;
                exp = '0;
                for (int c = 0; c < int'(N); c++) begin
                    obs[c] = io_tx;
                    exp[c] = frame_bit(byt, k);
                    tick();
                end
                check($sformatf("%s byte%0d bit%0d", tag, b, k), obs, exp);
            end
        end
    endtask

    task automatic wait_tx_low(input string tag);
        int k = 0;
        while (io_tx !== 1'b0 && k < 1000) begin
            tick();
            k++;
        end
        check(tag, 32'(io_tx), 32'd0);
    endtask

    task automatic wait_words(input logic [15:0] target, input string tag);
        int k = 0;
        while (words_sent !== target && k < 2000) begin
            tick();
            k++;
        end
        check(tag, 32'(words_sent), 32'(target));
    endtask

    initial begin
        logic [31:0] w6 [6];
        logic [15:0] base;
        w6[0] = 32'hDEADBEEF; w6[1] = 32'h01234567; w6[2] = 32'h80000001;
        w6[3] = 32'hFF00FF00; w6[4] = 32'h55555555; w6[5] = 32'hAAAAAAAA;

        reset_n    = 1'b1;
        data_valid = 1'b0;
        data_in    = '0;
        #1 reset_n = 1'b0;
        tick();
        tick();
        check("reset io_tx", 32'(io_tx), 32'd1);
        check("reset ready", 32'(data_ready), 32'd1);
        check("reset busy", 32'(busy), 32'd0);
        check("reset words", 32'(words_sent), 32'd0);
        reset_n = 1'b1;

        // Idle after reset
        for (int i = 0; i < 100; i++) begin
            tick();
            check($sformatf("idle cyc%0d", i), {13'd0, io_tx, busy, data_ready, words_sent},
                  {13'd0, 1'b1, 1'b0, 1'b1, 16'd0});
        end

        // Single word, latency and framing
        push(32'h11223344);
        check("w1 busy", 32'(busy), 32'd1);
        check("w1 tx at accept+0", 32'(io_tx), 32'd1);
        tick();
        check("w1 tx at accept+1", 32'(io_tx), 32'd1);
        tick();
        check_word(32'h11223344, "w1");
        check("w1 words", 32'(words_sent), 32'd1);
        check("w1 busy end", 32'(busy), 32'd0);
        check("w1 tx end", 32'(io_tx), 32'd1);

        // Overflow: first word leaves the FIFO, then 6 pushes; 4 fit, last 2 dropped
        base = words_sent;
        push(32'h0BADF00D);
        wait_tx_low("ovf start");
        for (int i = 0; i < 6; i++) begin
            push(w6[i]);
            check($sformatf("ovf ready%0d", i), 32'(data_ready), (i < 3) ? 32'd1 : 32'd0);
        end
        wait_words(base + 16'd1, "ovf first done");
        for (int i = 0; i < 4; i++) begin
            check_word(w6[i], $sformatf("ovf w%0d", i));
        end
        check("ovf words", 32'(words_sent), 32'(base + 16'd5));
        check("ovf busy end", 32'(busy), 32'd0);
        check("ovf tx end", 32'(io_tx), 32'd1);
        check("ovf ready end", 32'(data_ready), 32'd1);

        // Push while full on the pop cycle is refused; next push accepted in order
        base = words_sent;
        push(32'hA0A0A0A0);
        wait_tx_low("pp start");
        push(32'hB1B1B1B1);
        push(32'hC2C2C2C2);
        push(32'hD3D3D3D3);
        push(32'hE4E4E4E4);
        check("pp full", 32'(data_ready), 32'd0);
        repeat (WORD_CYC - 5) tick();
        check("pp ready before pop", 32'(data_ready), 32'd0);
        check("pp words before pop", 32'(words_sent), 32'(base));
        push(32'hF5F5F5F5);
        check("pp words after pop", 32'(words_sent), 32'(base + 16'd1));
        check("pp ready after pop", 32'(data_ready), 32'd1);
        push(32'h96969696);
        check("pp full again", 32'(data_ready), 32'd0);
        wait_words(base + 16'd2, "pp B done");
        check_word(32'hC2C2C2C2, "pp C");
        check_word(32'hD3D3D3D3, "pp D");
        check_word(32'hE4E4E4E4, "pp E");
        check_word(32'h96969696, "pp G");
        check("pp words", 32'(words_sent), 32'(base + 16'd6));
        check("pp busy end", 32'(busy), 32'd0);

`ifdef UART_TX_PARITY_EN
        // 0x07 carries parity 1, zero bytes carry parity 0
        push(32'h00000007);
        tick();
        tick();
        check_word(32'h00000007, "par");
        check("par busy end", 32'(busy), 32'd0);
`endif

        // Reset during data bit 3 of byte 2 (0x22: bit 3 is 0)
        push(32'h11223344);
        push(32'h77777777);
        wait_tx_low("rst start");
        repeat (2 * FB * N + 4 * N + 1) tick();
        check("rst pre tx", 32'(io_tx), 32'd0);
        check("rst pre busy", 32'(busy), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("rst tx async", 32'(io_tx), 32'd1);
        check("rst busy", 32'(busy), 32'd0);
        check("rst ready", 32'(data_ready), 32'd1);
        check("rst words", 32'(words_sent), 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check($sformatf("rst idle%0d", i), {30'd0, io_tx, busy}, {30'd0, 1'b1, 1'b0});
        end
        push(32'hA5C30F81);
        tick();
        check("rst fresh tx+1", 32'(io_tx), 32'd1);
        tick();
        check_word(32'hA5C30F81, "rst fresh");
        check("rst fresh words", 32'(words_sent), 32'd1);
        check("rst fresh busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
